// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core's load/store unit and the data memory.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with a valid/ready request/response bus and a
// configurable number of wait states between request acceptance and response.
module data_mem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus,
  output logic                  busy
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] rdata_q;
  logic        error_q;
  logic [31:0] mem [DEPTH];

  // Execution port: driven on the edge that enters RESP.
  logic              exec;
  logic              ex_write;
  logic [31:0]       ex_addr;
  logic [31:0]       ex_wdata;
  logic              ex_err;
  logic [ADDR_W-3:0] ex_idx;

  // Next-state logic; with zero wait states the request executes straight
  // from the bus lines on its acceptance edge, otherwise from the capture regs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    exec      = 1'b0;
    ex_write  = cap_write;
    ex_addr   = cap_addr;
    ex_wdata  = cap_wdata;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            state_nxt = RESP;
            exec      = 1'b1;
            ex_write  = bus.req_write;
            ex_addr   = bus.req_addr;
            ex_wdata  = bus.req_wdata;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = RESP;
          exec      = 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address decode: misaligned or beyond the decoded range is an error.
  always_comb begin
    ex_err = (ex_addr[1:0] != 2'b00) || ((ex_addr >> ADDR_W) != '0);
    ex_idx = ex_addr[ADDR_W-1:2];
  end

  // Control state, request capture and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && bus.req_valid) begin
        cap_write <= bus.req_write;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
      end
      if (exec) begin
        rdata_q <= (ex_write || ex_err) ? '0 : mem[ex_idx];
        error_q <= ex_err;
      end else if (state == RESP && bus.resp_ready) begin
        rdata_q <= '0;
        error_q <= 1'b0;
      end
    end
  end

  // Memory array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (exec && ex_write && !ex_err && !reset) mem[ex_idx] <= ex_wdata;
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one instance with two wait states, one with none.
module tb_data_mem_responder;

  logic clk;
  logic reset;
  logic busy_a;
  logic busy_b;
  int   tests;
  int   fails;

  data_mem_responder_if ifa ();
  data_mem_responder_if ifb ();

  data_mem_responder #(.ADDR_W(8), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .busy(busy_a)
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one request starting at a negedge; returns the response fields,
  // the number of cycles until resp_valid is seen, and how many cycles
  // req_ready stayed low. Ends on a negedge with req_ready high.
  task automatic txn(input bit sel, input logic w, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd,
                     output logic er, output int lat, output int low);
    int  n;
    bit  seen;
    rd = '0; er = 1'b0; lat = -1; low = 0; seen = 0;
    if (sel) begin
      ifb.req_valid = 1'b1; ifb.req_write = w; ifb.req_addr = a; ifb.req_wdata = d;
    end else begin
      ifa.req_valid = 1'b1; ifa.req_write = w; ifa.req_addr = a; ifa.req_wdata = d;
    end
    @(posedge clk);
    @(negedge clk);
    ifa.req_valid = 1'b0;
    ifb.req_valid = 1'b0;
    n = 1;
    while (n < 40) begin
      if (!seen && (sel ? ifb.resp_valid : ifa.resp_valid)) begin
        seen = 1;
        lat  = n;
        rd   = sel ? ifb.resp_rdata : ifa.resp_rdata;
        er   = sel ? ifb.resp_error : ifa.resp_error;
      end
      if (sel ? ifb.req_ready : ifa.req_ready) break;
      low++;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          low;
    int          n;

    tests = 0;
    fails = 0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0014, 32'h0,         32'h1234_5678, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h0,         1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0011, 32'h0,         32'h0,         1'b1};
    vecs[8]  = '{1'b1, 32'h0000_00FC, 32'h0BAD_CAFE, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'h0BAD_CAFE, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0014, 32'h0,         32'h1234_5678, 1'b0};
    vecs[11] = '{1'b1, 32'h8000_0010, 32'h5555_5555, 32'h0,         1'b1};
    vecs[12] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};

    ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifa.resp_ready = 1'b1;
    ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
    ifb.resp_ready = 1'b1;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_req_ready",  {31'b0, ifa.req_ready},  32'd1);
    chk("rst_resp_valid", {31'b0, ifa.resp_valid}, 32'd0);
    chk("rst_resp_rdata", ifa.resp_rdata,          32'd0);
    chk("rst_resp_error", {31'b0, ifa.resp_error}, 32'd0);
    chk("rst_busy",       {31'b0, busy_a},         32'd0);
    chk("rst_b_ready",    {31'b0, ifb.req_ready},  32'd1);

    for (int i = 0; i < 13; i++) begin
      txn(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, rd, er, lat, low);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_error", i), {31'b0, er}, {31'b0, vecs[i].exp_er});
      chk($sformatf("v%0d_latency", i), lat, 32'd3);
      chk($sformatf("v%0d_ready_low", i), low, 32'd3);
    end

    // Backpressure: response held while resp_ready low, new requests ignored.
    ifa.resp_ready = 1'b0;
    ifa.req_valid = 1'b1; ifa.req_write = 1'b0; ifa.req_addr = 32'h10; ifa.req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    ifa.req_valid = 1'b0;
    n = 0;
    while (!ifa.resp_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("bp_resp_seen", {31'b0, ifa.resp_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 32'h10; ifa.req_wdata = 32'h0;
      @(negedge clk);
      chk($sformatf("bp%0d_valid", k), {31'b0, ifa.resp_valid}, 32'd1);
      chk($sformatf("bp%0d_rdata", k), ifa.resp_rdata, 32'hDEAD_BEEF);
      chk($sformatf("bp%0d_busy", k), {31'b0, busy_a}, 32'd1);
      chk($sformatf("bp%0d_ready", k), {31'b0, ifa.req_ready}, 32'd0);
    end
    ifa.req_valid = 1'b0;
    ifa.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_valid", {31'b0, ifa.resp_valid}, 32'd0);
    chk("bp_after_rdata", ifa.resp_rdata, 32'd0);
    chk("bp_after_ready", {31'b0, ifa.req_ready}, 32'd1);
    txn(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, low);
    chk("bp_reload", rd, 32'hDEAD_BEEF);

    // Reset while waiting abandons the store.
    txn(1'b0, 1'b1, 32'h20, 32'h1111_1111, rd, er, lat, low);
    ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 32'h20; ifa.req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    ifa.req_valid = 1'b0;
    chk("rw_busy_wait", {31'b0, busy_a}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rw_req_ready",  {31'b0, ifa.req_ready},  32'd1);
    chk("rw_resp_valid", {31'b0, ifa.resp_valid}, 32'd0);
    chk("rw_resp_rdata", ifa.resp_rdata,          32'd0);
    chk("rw_resp_error", {31'b0, ifa.resp_error}, 32'd0);
    chk("rw_busy",       {31'b0, busy_a},         32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    txn(1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, low);
    chk("rw_old_value", rd, 32'h1111_1111);
    txn(1'b0, 1'b1, 32'h20, 32'h0, rd, er, lat, low);
    txn(1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, low);
    chk("rw_zero_value", rd, 32'h0);

    // Zero-wait-state instance: one-cycle response, two-cycle pairs.
    txn(1'b1, 1'b1, 32'h04, 32'hA5A5_A5A5, rd, er, lat, low);
    chk("l0_st_rdata", rd, 32'h0);
    chk("l0_st_error", {31'b0, er}, 32'd0);
    chk("l0_st_latency", lat, 32'd1);
    chk("l0_st_ready_low", low, 32'd1);
    txn(1'b1, 1'b0, 32'h04, 32'h0, rd, er, lat, low);
    chk("l0_ld_rdata", rd, 32'hA5A5_A5A5);
    chk("l0_ld_latency", lat, 32'd1);
    chk("l0_ld_ready_low", low, 32'd1);
    txn(1'b1, 1'b0, 32'h06, 32'h0, rd, er, lat, low);
    chk("l0_misaligned_error", {31'b0, er}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
